// File: rtl/axis_rr_arbiter.sv
// N-to-1 AXI-Stream arbiter: round-robin grant, locked until the granted
// source's tlast beat is accepted, with a single registered output stage.
module axis_rr_arbiter #(
  parameter int N      = 4,
  parameter int DATA_W = 4,
  localparam int ID_W  = $clog2(N)
) (
  input  logic                clk_i,
  input  logic                arstn_i,
  input  logic [N-1:0]        s_tvalid_i,
  output logic [N-1:0]        s_tready_o,
  input  logic [N*DATA_W-1:0] s_tdata_i,
  input  logic [N-1:0]        s_tlast_i,
  output logic                m_tvalid_o,
  input  logic                m_tready_i,
  output logic [DATA_W-1:0]   m_tdata_o,
  output logic                m_tlast_o,
  output logic [ID_W-1:0]     m_tid_o,
  output logic                busy_o
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t          state;
  logic [ID_W-1:0] g;
  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] pick;
  logic            can_load;
  logic            src_hs;

  // Scan downwards so the last hit is the closest requester at or after ptr;
  // the ID_W-bit add wraps modulo N because N is a power of two.
  always_comb begin
    pick = ptr;
    for (int unsigned i = N; i > 0; i--) begin
      if (s_tvalid_i[ptr + ID_W'(i - 1)]) pick = ptr + ID_W'(i - 1);
    end
  end

  assign can_load = !m_tvalid_o || m_tready_i;
  assign src_hs   = (state == LOCKED) && s_tvalid_i[g] && can_load;
  assign busy_o   = (state == LOCKED);

  always_comb begin
    s_tready_o = '0;
    if (state == LOCKED) s_tready_o[g] = can_load;
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state      <= IDLE;
      g          <= '0;
      ptr        <= '0;
      m_tvalid_o <= 1'b0;
      m_tdata_o  <= '0;
      m_tlast_o  <= 1'b0;
      m_tid_o    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|s_tvalid_i) begin
            g     <= pick;
            state <= LOCKED;
          end
        end
        LOCKED: begin
          if (src_hs && s_tlast_i[g]) begin
            ptr   <= g + ID_W'(1);
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (src_hs) begin
        m_tvalid_o <= 1'b1;
        m_tdata_o  <= s_tdata_i[g*DATA_W +: DATA_W];
        m_tlast_o  <= s_tlast_i[g];
        m_tid_o    <= g;
      end else if (m_tready_i) begin
        m_tvalid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Directed bench for axis_rr_arbiter: per-source beat queues feed the DUT,
// expected output beats sit in a scoreboard queue popped on each output accept.
module tb_axis_rr_arbiter;

  localparam int N      = 4;
  localparam int DATA_W = 4;

  typedef struct packed {
    logic [3:0] d;
    logic       l;
  } beat_t;

  typedef struct packed {
    logic [1:0] id;
    logic [3:0] d;
    logic       l;
  } exp_t;

  logic                clk_i = 1'b0;
  logic                arstn_i;
  logic [N-1:0]        s_tvalid_i;
  logic [N-1:0]        s_tready_o;
  logic [N*DATA_W-1:0] s_tdata_i;
  logic [N-1:0]        s_tlast_i;
  logic                m_tvalid_o;
  logic                m_tready_i;
  logic [DATA_W-1:0]   m_tdata_o;
  logic                m_tlast_o;
  logic [1:0]          m_tid_o;
  logic                busy_o;

  axis_rr_arbiter #(.N(N), .DATA_W(DATA_W)) dut (
    .clk_i      (clk_i),
    .arstn_i    (arstn_i),
    .s_tvalid_i (s_tvalid_i),
    .s_tready_o (s_tready_o),
    .s_tdata_i  (s_tdata_i),
    .s_tlast_i  (s_tlast_i),
    .m_tvalid_o (m_tvalid_o),
    .m_tready_i (m_tready_i),
    .m_tdata_o  (m_tdata_o),
    .m_tlast_o  (m_tlast_o),
    .m_tid_o    (m_tid_o),
    .busy_o     (busy_o)
  );

  always #5 clk_i = ~clk_i;

  beat_t src_q[N][$];
  exp_t  sb[$];
  int    total  = 0;
  int    passes = 0;
  int    fails  = 0;
  int    cyc    = 0;
  int    last_cyc;
  bit    have_last;
  int    gap_exp = 0;
  bit    mon_en  = 1'b1;
  logic  rdy     = 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic send(input int k, input logic [3:0] d, input logic l);
    beat_t b;
    b.d = d;
    b.l = l;
    src_q[k].push_back(b);
  endtask

  task automatic expect_beat(input int k, input logic [3:0] d, input logic l);
    exp_t e;
    e.id = 2'(k);
    e.d  = d;
    e.l  = l;
    sb.push_back(e);
  endtask

  // Drive at negedge, sample just after, retire accepted source beats at posedge.
  task automatic tick();
    logic [N-1:0]        vld;
    logic [N-1:0]        lst;
    logic [N*DATA_W-1:0] dat;
    logic [N-1:0]        hs;
    exp_t                e;
    @(negedge clk_i);
    vld = '0;
    lst = '0;
    dat = '0;
    for (int k = 0; k < N; k++) begin
      if (src_q[k].size() > 0) begin
        vld[k]               = 1'b1;
        dat[k*DATA_W +: DATA_W] = src_q[k][0].d;
        lst[k]               = src_q[k][0].l;
      end
    end
    s_tvalid_i = vld;
    s_tdata_i  = dat;
    s_tlast_i  = lst;
    m_tready_i = rdy;
    #1;
    hs = s_tvalid_i & s_tready_o;
    check("ready_onehot_or_zero", 32'($countones(s_tready_o) <= 1), 32'd1);
    if (mon_en && m_tvalid_o && m_tready_i) begin
      total++;
      assert (sb.size() > 0) passes++;
      else begin
        fails++;
        $error("FAIL unexpected_beat observed id=%0d data=0x%0h expected=none", m_tid_o, m_tdata_o);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("out_id",   32'(m_tid_o),   32'(e.id));
        check("out_data", 32'(m_tdata_o), 32'(e.d));
        check("out_last", 32'(m_tlast_o), 32'(e.l));
      end
      if (have_last && gap_exp != 0) check("beat_gap", 32'(cyc - last_cyc), 32'(gap_exp));
      have_last = 1'b1;
      last_cyc  = cyc;
    end
    @(posedge clk_i);
    cyc++;
    for (int k = 0; k < N; k++) begin
      if (hs[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
    end
  endtask

  task automatic drain(input int max_ticks, input int gap);
    int n;
    bit done;
    n         = 0;
    done      = 1'b0;
    gap_exp   = gap;
    have_last = 1'b0;
    while (!done && n < max_ticks) begin
      tick();
      #1;
      n++;
      done = (sb.size() == 0) && !m_tvalid_o;
      for (int k = 0; k < N; k++) if (src_q[k].size() > 0) done = 1'b0;
    end
    check("drain_complete", 32'(done), 32'd1);
  endtask

  initial begin
    int n;
    arstn_i    = 1'b0;
    s_tvalid_i = '0;
    s_tdata_i  = '0;
    s_tlast_i  = '0;
    m_tready_i = 1'b1;

    // Reset held with every source requesting, then fairness with 1-beat packets.
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < N; k++) send(k, 4'(k), 1'b1);
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < N; k++) expect_beat(k, 4'(k), 1'b1);
    for (int i = 0; i < 2; i++) begin
      tick();
      #1;
      check("rst_m_tvalid", 32'(m_tvalid_o), 32'd0);
      check("rst_s_tready", 32'(s_tready_o), 32'd0);
      check("rst_busy",     32'(busy_o),     32'd0);
      check("rst_m_tid",    32'(m_tid_o),    32'd0);
    end
    #1 arstn_i = 1'b1;
    tick();
    #1;
    check("first_grant_ready", 32'(s_tready_o), 32'b0001);
    check("first_grant_busy",  32'(busy_o),     32'd1);
    drain(100, 2);

    // Single source 2, back-to-back 3-beat packet.
    send(2, 4'hA, 1'b0); send(2, 4'hB, 1'b0); send(2, 4'hC, 1'b1);
    expect_beat(2, 4'hA, 1'b0); expect_beat(2, 4'hB, 1'b0); expect_beat(2, 4'hC, 1'b1);
    drain(50, 1);
    check("single_busy_after", 32'(busy_o), 32'd0);

    // Pointer now 3: source 3 wins over source 0.
    send(0, 4'h1, 1'b1); send(3, 4'h2, 1'b1);
    expect_beat(3, 4'h2, 1'b1); expect_beat(0, 4'h1, 1'b1);
    drain(50, 0);

    // Lock: source 0 requests mid-packet of source 1, waits for its tlast.
    send(1, 4'h8, 1'b0); send(1, 4'h9, 1'b0); send(1, 4'hA, 1'b0); send(1, 4'hB, 1'b1);
    expect_beat(1, 4'h8, 1'b0); expect_beat(1, 4'h9, 1'b0);
    expect_beat(1, 4'hA, 1'b0); expect_beat(1, 4'hB, 1'b1);
    expect_beat(0, 4'hE, 1'b1);
    have_last = 1'b0;
    gap_exp   = 0;
    tick();
    tick();
    send(0, 4'hE, 1'b1);
    n = 0;
    while (src_q[1].size() > 0 && n < 20) begin
      tick();
      #1;
      n++;
      if (src_q[1].size() > 0) check("lock_src0_blocked", 32'(s_tready_o[0]), 32'd0);
    end
    drain(50, 0);

    // Backpressure: beat 0x5 held in the output register for 3 cycles.
    rdy = 1'b0;
    send(1, 4'h5, 1'b0); send(1, 4'h6, 1'b0); send(1, 4'h7, 1'b1);
    expect_beat(1, 4'h5, 1'b0); expect_beat(1, 4'h6, 1'b0); expect_beat(1, 4'h7, 1'b1);
    n = 0;
    do begin
      tick();
      #1;
      n++;
    end while (!m_tvalid_o && n < 20);
    check("bp_first_valid", 32'(m_tvalid_o), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      check("bp_hold_valid", 32'(m_tvalid_o), 32'd1);
      check("bp_hold_data",  32'(m_tdata_o),  32'h5);
      check("bp_s_tready",   32'(s_tready_o), 32'd0);
    end
    rdy = 1'b1;
    drain(50, 1);

    // Asynchronous reset during beat 2 of 4 from source 2.
    mon_en = 1'b0;
    send(2, 4'h1, 1'b0); send(2, 4'h2, 1'b0); send(2, 4'h3, 1'b0); send(2, 4'h4, 1'b1);
    n = 0;
    while (src_q[2].size() > 2 && n < 20) begin
      tick();
      n++;
    end
    check("ar_two_beats_taken", 32'(src_q[2].size()), 32'd2);
    #2 arstn_i = 1'b0;
    #1;
    check("ar_m_tvalid", 32'(m_tvalid_o), 32'd0);
    check("ar_m_tdata",  32'(m_tdata_o),  32'd0);
    check("ar_m_tlast",  32'(m_tlast_o),  32'd0);
    check("ar_busy",     32'(busy_o),     32'd0);
    check("ar_s_tready", 32'(s_tready_o), 32'd0);
    for (int k = 0; k < N; k++) src_q[k].delete();
    sb.delete();
    tick();
    #2 arstn_i = 1'b1;
    mon_en = 1'b1;
    send(0, 4'h3, 1'b1); send(3, 4'h4, 1'b1);
    expect_beat(0, 4'h3, 1'b1); expect_beat(3, 4'h4, 1'b1);
    drain(50, 2);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/axis_rr_arbiter.md
Name: axis_rr_arbiter

Overview:
- N-to-1 AXI-Stream arbiter. Shares one downstream stream sink, such as a BUFFER register stage, among N upstream requesters.
- Uses round-robin grant with packet lock: a granted source owns the output until its tlast beat is accepted.
- The output side is a single registered stage, so the downstream sees no combinational path from any source.

Parameters:
- N, 4, number of requesters; legal values 2, 4, 8.
- DATA_W, 4, tdata width per stream.
- ID_W, log2(N), width of the grant index and m_tid_o; derived, not overridden.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- arstn_i  in  1  reset, asynchronous assert, active-low.
- s_tvalid_i  in  N  per-source valid; bit k belongs to source k.
- s_tready_o  out  N  per-source ready; one-hot or zero.
- s_tdata_i  in  N*DATA_W  per-source data; source k at bits [k*DATA_W +: DATA_W].
- s_tlast_i  in  N  per-source end-of-packet.
- m_tvalid_o  out  1  output valid (registered).
- m_tready_i  in  1  downstream ready.
- m_tdata_o  out  DATA_W  output data (registered).
- m_tlast_o  out  1  output end-of-packet (registered).
- m_tid_o  out  ID_W  index of the source that produced the current output beat.
- busy_o  out  1  high while in LOCKED.

Behaviour:
- Reset (arstn_i low, asynchronous, takes effect immediately):
  - state=IDLE, grant index g=0, rr pointer ptr=0.
  - m_tvalid_o=0, m_tdata_o=0, m_tlast_o=0, m_tid_o=0, busy_o=0, s_tready_o=0.
- States: IDLE and LOCKED.
- IDLE:
  - s_tready_o=0 (no beats accepted).
  - If any s_tvalid_i bit is set, pick the first set index searching ptr, ptr+1, ..., wrapping modulo N. Register it into g and go to LOCKED.
  - Grant latency is 1 cycle: the earliest source beat accepted is the cycle after valid is first seen in IDLE.
- LOCKED:
  - can_load = !m_tvalid_o || m_tready_i.
  - s_tready_o[g]=can_load; all other bits are 0.
  - Source handshake = s_tvalid_i[g] && s_tready_o[g].
  - On a source handshake: m_tdata_o, m_tlast_o and m_tvalid_o=1 load from source g, and m_tid_o=g.
  - On a source handshake with s_tlast_i[g]=1: go to IDLE and set ptr=(g+1) mod N.
  - Otherwise stay in LOCKED; grant is held even if s_tvalid_i[g] drops mid-packet (no re-arbitration).
- Output register:
  - If m_tready_i && m_tvalid_o and there is no new load, clear m_tvalid_o.
  - Load and drain in the same cycle gives full throughput: 1 beat/cycle while the downstream is ready.
  - m_tdata_o, m_tlast_o and m_tid_o hold stable while m_tvalid_o=1 && !m_tready_i. Never change a pending beat.
- Packet gap: one IDLE cycle between packets, i.e. one bubble per packet boundary. This is accepted.
- Non-granted sources may assert, hold or drop valid freely; this must have no effect until they are granted.
- Simultaneous tlast accept and new requests: the new requests are evaluated in the following IDLE cycle using the updated ptr.
- The last beat of a packet may still sit in the output register while the next grant is made. The next packet's beats wait only on can_load.
- Reset mid-packet: the partial packet is dropped and the output beat is lost. After release, arbitration restarts with ptr=0.
- No beat may be duplicated or dropped in normal operation. Output order within a source equals input order.

Test Plan:
- Reset: hold arstn_i low with all s_tvalid_i=1 → m_tvalid_o=0, s_tready_o=0, busy_o=0. Release → the next cycle grants source 0.
- Single source: source 2 sends a 3-beat packet 0xA, 0xB, 0xC (tlast on 0xC), m_tready_i=1 → beats appear on consecutive cycles with m_tid_o=2 and m_tlast_o=1 on 0xC. busy_o drops after the 0xC accept and ptr becomes 3.
- Fairness: all 4 sources continuously valid with 1-beat packets (tlast=1, data=source index), m_tready_i=1 → output order 0,1,2,3,0,1 with one bubble between packets.
- Lock: source 1 is mid 4-beat packet when source 0 raises valid → s_tready_o[0] stays 0 until source 1's tlast is accepted. Source 0 is then granted next (ptr=2 scan wraps to 0 when sources 2 and 3 are idle).
- Backpressure: m_tready_i=0 for 3 cycles with m_tvalid_o=1 and data 0x5 → m_tdata_o stays 0x5 and s_tready_o=0. After release, the next source beat 0x6 follows with no loss or duplicate.
- Async reset mid-packet: assert arstn_i low between clock edges during beat 2 of 4 → outputs clear immediately without waiting for an edge. After release, source 0 is granted first.
